// File: rtl/hs4_pkg.sv
// hs4_pkg
// Shared types for the 4-phase bundled-data bridges at the async/sync boundary.
// Contents:
//   hs4_rx_state_t  receive-side handshake FSM states
//     IDLE  waiting for a synchronised request and free FIFO space
//     ACK   token captured, in_ack asserted, waiting for request to return low
//     RTZ   one quiet cycle so the next request rise is seen fresh
package hs4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        RTZ  = 2'd2
    } hs4_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// sync_ff
// Multi-flop synchroniser for a single asynchronous control bit.
// Shared by the receive and transmit handshake bridges.
// Ports:
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low reset, clears every stage to 0
//   d      in  asynchronous input bit
//   q      out synchronised bit, STAGES clock edges after d
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_reg[0] <= 1'b0;
                    end else begin
                        sync_reg[0] <= d;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/hs4_rx_bridge.sv
// hs4_rx_bridge
// Receives 4-phase bundled-data tokens from an asynchronous C-element pipeline
// and presents them to the clocked core as a first-word-fall-through
// valid/ready stream.
// Ports:
//   clk        in  core clock
//   rst_n      in  asynchronous active-low reset
//   in_req     in  4-phase request from upstream (asynchronous)
//   in_data    in  bundled payload, stable while in_req is high
//   in_ack     out 4-phase acknowledge to upstream
//   out_valid  out FIFO head valid
//   out_data   out FIFO head, 0 when empty
//   out_ready  in  consumer takes the head this cycle
//   count      out FIFO occupancy, 0..DEPTH
module hs4_rx_bridge
    import hs4_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_req,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ack,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic                req_s;
    hs4_rx_state_t       state_reg;
    hs4_rx_state_t       state_next;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                push;
    logic                pop;
    logic                full;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_req),
        .q     (req_s)
    );

    // Full is judged on the registered count only, so a pop in the same
    // cycle does not open a slot until the following cycle.
    assign full = (count_reg == DEPTH_C);
    assign pop  = (count_reg != '0) && out_ready;

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        case (state_reg)
            IDLE: begin
                // While full, stay here with in_ack low; upstream stalls.
                if (req_s && !full) begin
                    push       = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_next = RTZ;
                end
            end
            RTZ: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload storage carries no reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    assign in_ack    = (state_reg == ACK);
    assign out_valid = (count_reg != '0);
    assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;
    assign count     = count_reg;

endmodule

// File: tb/tb_hs4_rx_bridge.sv
module tb_hs4_rx_bridge;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int BOUND  = 200;

    logic              clk;
    logic              rst_n;
    logic              in_req;
    logic [DATA_W-1:0] in_data;
    logic              in_ack;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [2:0]        count;

    int n_assert;
    int n_fail;
    int max_count;
    int lat;
    logic ack_prev;
    logic rand_ready;
    logic [DATA_W-1:0] exp_q [$];

    hs4_rx_bridge #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle, starting and ending at a falling edge.
    // The reference model: a token enters the queue when its handshake is
    // acknowledged and leaves when the consumer takes it.
    task automatic step();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
            check("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("pop_data", out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (in_ack && !ack_prev) exp_q.push_back(in_data);
        ack_prev = in_ack;
        check("count", 32'(count), 32'(exp_q.size()));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 32'd0);
        if (int'(count) > max_count) max_count = int'(count);
    endtask

    task automatic wait_ack(input logic level, output int n);
        n = 0;
        while (in_ack !== level && n < BOUND) begin
            step();
            n++;
        end
        check("ack_wait", 32'(in_ack), 32'(level));
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        int n;
        in_data = d;
        in_req  = 1'b1;
        wait_ack(1'b1, n);
        in_req = 1'b0;
        wait_ack(1'b0, n);
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < BOUND) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        step();
        check("drain_empty", 32'(count), 32'd0);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        max_count  = 0;
        ack_prev   = 1'b0;
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        in_req     = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(in_ack), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data", out_data, 32'd0);
        rst_n = 1'b1;
        step();

        // Single token with latency measurement
        in_data = 32'hCAFE_0001;
        in_req  = 1'b1;
        wait_ack(1'b1, lat);
        check("rise_latency", 32'(lat), 32'd3);
        check("single_count", 32'(count), 32'd1);
        check("single_data", out_data, 32'hCAFE_0001);
        in_req = 1'b0;
        wait_ack(1'b0, lat);
        check("fall_latency", 32'(lat), 32'd3);
        drain();

        // Fill beyond depth; fifth request must stall until a slot frees
        for (int i = 1; i <= 4; i++) send(32'(i));
        check("fill_count", 32'(count), 32'd4);
        in_data = 32'd5;
        in_req  = 1'b1;
        repeat (10) step();
        check("fill_stall_ack", 32'(in_ack), 32'd0);
        check("fill_stall_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop_while_full", 32'(count), 32'd3);
        check("no_same_cycle_push", 32'(in_ack), 32'd0);
        step();
        check("deferred_push_ack", 32'(in_ack), 32'd1);
        check("deferred_push_count", 32'(count), 32'd4);
        check("head_after_pop", out_data, 32'd2);
        in_req = 1'b0;
        wait_ack(1'b0, lat);
        drain();

        // Streaming with the consumer always ready
        max_count = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send($urandom);
        drain();
        check("stream_max_count", 32'(max_count), 32'd1);

        // Sticky request: exactly one push however long req stays high
        out_ready = 1'b0;
        in_data   = $urandom;
        in_req    = 1'b1;
        repeat (20) step();
        check("sticky_ack", 32'(in_ack), 32'd1);
        check("sticky_count", 32'(count), 32'd1);
        in_req = 1'b0;
        wait_ack(1'b0, lat);
        drain();

        // Random consumer backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) send($urandom);
        rand_ready = 1'b0;
        drain();

        // Reset in the middle of a handshake
        send($urandom);
        send($urandom);
        in_data = $urandom;
        in_req  = 1'b1;
        wait_ack(1'b1, lat);
        check("pre_reset_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_reset_ack", 32'(in_ack), 32'd0);
        check("mid_reset_valid", 32'(out_valid), 32'd0);
        check("mid_reset_count", 32'(count), 32'd0);
        exp_q.delete();
        ack_prev = 1'b0;
        in_req   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send(32'h1234_ABCD);
        check("post_reset_data", out_data, 32'h1234_ABCD);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
